intadd: RTL and testbench

INTADD -- requirements
Module: intadd

---
 rtl/intadd.sv | 173 +++++++++++++++++
 tb/tb_intadd.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/intadd.sv
// Packed-lane integer adder with a one-cycle registered result.
//
// Two lane modes are selected by the precision fields of the micro-instruction:
//   32-bit mode : four 32-bit lanes, dst_reg0 = src_reg0 + src_reg1, dst_reg1 = 0.
//   8/4-bit mode: sixteen byte lanes of src_reg0 + src_reg1 + src_reg2 into dst_reg0
//                 and thirty-two nibble lanes of the same three sources into dst_reg1.
// Any other precision combination is a no-op. Sums wrap silently; per-lane overflow
// (carry-out for unsigned lanes, two's-complement overflow for signed lanes) goes to st.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous reset, ACTIVE HIGH despite the name (1 = clear)
//   src_reg0-2 - 128-bit operand registers
//   cru_intadd - micro-instruction {inst_valid, prec_s0[1:0], prec_s1[1:0], prec_s2[1:0],
//                sign_s0, sign_s1, sign_s2, update_st}
//   dst_reg0   - primary result (32-bit lanes or byte lanes)
//   dst_reg1   - secondary result (nibble lanes, zero in 32-bit mode)
//   st         - per-lane overflow status

module intadd (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] src_reg0,
  input  logic [127:0] src_reg1,
  input  logic [127:0] src_reg2,
  input  logic [10:0]  cru_intadd,
  output logic [127:0] dst_reg0,
  output logic [127:0] dst_reg1,
  output logic [127:0] st
);

  // Micro-instruction fields
  logic       inst_valid;
  logic [1:0] precision_s0;
  logic [1:0] precision_s1;
  logic [1:0] precision_s2;
  logic       sign_s0;
  logic       sign_s1;
  logic       sign_s2;
  logic       update_st;

  assign inst_valid   = cru_intadd[10];
  assign precision_s0 = cru_intadd[9:8];
  assign precision_s1 = cru_intadd[7:6];
  assign precision_s2 = cru_intadd[5:4];
  assign sign_s0      = cru_intadd[3];
  assign sign_s1      = cru_intadd[2];
  assign sign_s2      = cru_intadd[1];
  assign update_st    = cru_intadd[0];

  // Mode decode
  logic mode_32;
  logic mode_84;
  logic mode_ok;

  assign mode_32 = (precision_s0 == 2'b11) && (precision_s1 == 2'b11) &&
                   (precision_s2 == 2'b11);
  assign mode_84 = (precision_s0 == 2'b00) && (precision_s1 == 2'b00) &&
                   (precision_s2 == 2'b00);
  assign mode_ok = mode_32 || mode_84;

  // Result formats: a lane is signed if any operand taking part in it is signed.
  logic signed_32;
  logic signed_84;

  assign signed_32 = sign_s0 | sign_s1;
  assign signed_84 = sign_s0 | sign_s1 | sign_s2;

  // Operand extension helpers. The extra headroom bits hold the exact sum of
  // all operands in any mix of signed and unsigned extension without wrapping.
  function automatic logic [34:0] ext32(input logic [31:0] v, input logic s);
    return {{3{s & v[31]}}, v};
  endfunction

  function automatic logic [10:0] ext8(input logic [7:0] v, input logic s);
    return {{3{s & v[7]}}, v};
  endfunction

  function automatic logic [6:0] ext4(input logic [3:0] v, input logic s);
    return {{3{s & v[3]}}, v};
  endfunction

  // Overflow tests on the exact sums. Signed: the bits from the lane's sign bit
  // upward must all agree. Unsigned: everything above the lane must be zero.
  function automatic logic ovf32(input logic [34:0] sum, input logic sgn);
    if (sgn) begin
      return !((sum[34:31] == 4'h0) || (sum[34:31] == 4'hF));
    end
    return (sum[34:32] != 3'b000);
  endfunction

  function automatic logic ovf8(input logic [10:0] sum, input logic sgn);
    if (sgn) begin
      return !((sum[10:7] == 4'h0) || (sum[10:7] == 4'hF));
    end
    return (sum[10:8] != 3'b000);
  endfunction

  function automatic logic ovf4(input logic [6:0] sum, input logic sgn);
    if (sgn) begin
      return !((sum[6:3] == 4'h0) || (sum[6:3] == 4'hF));
    end
    return (sum[6:4] != 3'b000);
  endfunction

  // 32-bit lanes
  logic [127:0] res_32;
  logic [127:0] st_32;

  always_comb begin
    logic [34:0] sum;
    res_32 = '0;
    st_32  = '0;
    sum    = '0;
    for (int i = 0; i < 4; i++) begin
      sum = ext32(src_reg0[32*i +: 32], sign_s0) + ext32(src_reg1[32*i +: 32], sign_s1);
      res_32[32*i +: 32] = sum[31:0];
      st_32[i]           = ovf32(sum, signed_32);
    end
  end

  // Byte lanes into dst_reg0, nibble lanes into dst_reg1
  logic [127:0] res_8;
  logic [127:0] res_4;
  logic [127:0] st_84;

  always_comb begin
    logic [10:0] sum8;
    logic [6:0]  sum4;
    res_8 = '0;
    res_4 = '0;
    st_84 = '0;
    sum8  = '0;
    sum4  = '0;
    for (int i = 0; i < 16; i++) begin
      sum8 = ext8(src_reg0[8*i +: 8], sign_s0) + ext8(src_reg1[8*i +: 8], sign_s1) +
             ext8(src_reg2[8*i +: 8], sign_s2);
      res_8[8*i +: 8] = sum8[7:0];
      st_84[i]        = ovf8(sum8, signed_84);
    end
    for (int j = 0; j < 32; j++) begin
      sum4 = ext4(src_reg0[4*j +: 4], sign_s0) + ext4(src_reg1[4*j +: 4], sign_s1) +
             ext4(src_reg2[4*j +: 4], sign_s2);
      res_4[4*j +: 4] = sum4[3:0];
      st_84[16 + j]   = ovf4(sum4, signed_84);
    end
  end

  // Output registers
  logic [127:0] dst0_q;
  logic [127:0] dst1_q;
  logic [127:0] st_q;

  // Reset wins over any instruction presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      dst0_q <= '0;
      dst1_q <= '0;
      st_q   <= '0;
    end else if (inst_valid && mode_ok) begin
      dst0_q <= mode_32 ? res_32 : res_8;
      dst1_q <= mode_32 ? '0 : res_4;
      if (update_st) begin
        st_q <= mode_32 ? st_32 : st_84;
      end
    end
  end

  assign dst_reg0 = dst0_q;
  assign dst_reg1 = dst1_q;
  assign st       = st_q;

endmodule

// File: tb/tb_intadd.sv
module tb_intadd;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] src_reg0, src_reg1, src_reg2;
  logic [10:0]  cru_intadd;
  logic [127:0] dst_reg0, dst_reg1, st;

  always #5 clk = ~clk;

  intadd u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_reg0   (src_reg0),
    .src_reg1   (src_reg1),
    .src_reg2   (src_reg2),
    .cru_intadd (cru_intadd),
    .dst_reg0   (dst_reg0),
    .dst_reg1   (dst_reg1),
    .st         (st)
  );

  int total = 0;
  int bad   = 0;

  // Expected register contents
  logic [127:0] exp_d0 = '0;
  logic [127:0] exp_d1 = '0;
  logic [127:0] exp_st = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [10:0] mk_cru(input bit v, input logic [1:0] p0, input logic [1:0] p1,
                                         input logic [1:0] p2, input bit g0, input bit g1,
                                         input bit g2, input bit u);
    return {v, p0, p1, p2, g0, g1, g2, u};
  endfunction

  // Lane i of width w, as a plain non-negative number
  function automatic longint lane(input logic [127:0] v, input int w, input int i);
    logic [127:0] t;
    t = (v >> (w * i)) & ((128'd1 << w) - 128'd1);
    return longint'(t[63:0]);
  endfunction

  // Interpret a lane value as signed or unsigned integer
  function automatic longint val(input longint raw, input int w, input bit s);
    if (s && (((raw >> (w - 1)) & 64'sd1) != 0)) return raw - (64'sd1 << w);
    return raw;
  endfunction

  // Adds the lanes with ordinary integer arithmetic and range-checks the result.
  task automatic lane_add(input int w, input int n, input bit three, input bit g0, input bit g1,
                          input bit g2, output logic [127:0] res, output logic [63:0] ovf);
    longint sum, lo, hi;
    bit sgn;
    logic [127:0] r;
    sgn = g0 | g1 | (three & g2);
    lo  = sgn ? -(64'sd1 << (w - 1)) : 64'sd0;
    hi  = sgn ? (64'sd1 << (w - 1)) - 1 : (64'sd1 << w) - 1;
    res = '0;
    ovf = '0;
    for (int i = 0; i < n; i++) begin
      sum = val(lane(src_reg0, w, i), w, g0) + val(lane(src_reg1, w, i), w, g1);
      if (three) sum += val(lane(src_reg2, w, i), w, g2);
      ovf[i] = (sum < lo) || (sum > hi);
      r = 128'(sum & ((64'sd1 << w) - 1));
      res |= r << (w * i);
    end
  endtask

  task automatic model();
    logic [1:0] p0, p1, p2;
    logic [127:0] r0, r1, nst;
    logic [63:0] o0, o1;
    bit g0, g1, g2;
    p0 = cru_intadd[9:8];
    p1 = cru_intadd[7:6];
    p2 = cru_intadd[5:4];
    g0 = cru_intadd[3];
    g1 = cru_intadd[2];
    g2 = cru_intadd[1];
    if (rst_n) begin
      exp_d0 = '0;
      exp_d1 = '0;
      exp_st = '0;
    end else if (cru_intadd[10] && p0 == 2'b11 && p1 == 2'b11 && p2 == 2'b11) begin
      lane_add(32, 4, 1'b0, g0, g1, g2, r0, o0);
      exp_d0 = r0;
      exp_d1 = '0;
      if (cru_intadd[0]) exp_st = {124'd0, o0[3:0]};
    end else if (cru_intadd[10] && p0 == 2'b00 && p1 == 2'b00 && p2 == 2'b00) begin
      lane_add(8, 16, 1'b1, g0, g1, g2, r0, o0);
      lane_add(4, 32, 1'b1, g0, g1, g2, r1, o1);
      nst = {80'd0, o1[31:0], o0[15:0]};
      exp_d0 = r0;
      exp_d1 = r1;
      if (cru_intadd[0]) exp_st = nst;
    end
  endtask

  task automatic step(input string tag, input bit rst, input logic [10:0] cru,
                      input logic [127:0] s0, input logic [127:0] s1, input logic [127:0] s2);
    rst_n      = rst;
    cru_intadd = cru;
    src_reg0   = s0;
    src_reg1   = s1;
    src_reg2   = s2;
    @(posedge clk);
    #1;
    model();
    check({tag, "_d0"}, dst_reg0, exp_d0);
    check({tag, "_d1"}, dst_reg1, exp_d1);
    check({tag, "_st"}, st, exp_st);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rnd_src();
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: w = 32'h7FFF_FFFF;
      1: w = 32'h8000_0000;
      2: w = 32'hFFFF_FFFF;
      3: w = $urandom();
      default: return rnd128();
    endcase
    return {4{w}};
  endfunction

  localparam logic [127:0] Ones = {128{1'b1}};
  localparam logic [127:0] P55  = {16{8'h55}};

  initial begin
    logic [10:0] c;
    logic [1:0] p0, p1, p2;

    // Reset with an instruction present: instruction abandoned
    step("rst", 1'b1, mk_cru(1, 2'b11, 2'b11, 2'b11, 1, 1, 0, 1), Ones, Ones, Ones);
    check("rst_zero_d0", dst_reg0, 128'd0);
    check("rst_zero_st", st, 128'd0);

    // 32-bit signed positive overflow
    step("s32pos", 1'b0, mk_cru(1, 2'b11, 2'b11, 2'b11, 1, 1, 0, 1),
         {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, rnd128());
    check("s32pos_const_d0", dst_reg0, {4{32'h8000_0000}});
    check("s32pos_const_st", st, 128'hF);

    // 32-bit signed negative overflow
    step("s32neg", 1'b0, mk_cru(1, 2'b11, 2'b11, 2'b11, 1, 1, 1, 1),
         {4{32'h8000_0000}}, {4{32'hFFFF_FFFF}}, rnd128());
    check("s32neg_const_d0", dst_reg0, {4{32'h7FFF_FFFF}});
    check("s32neg_const_st", st, 128'hF);

    // 32-bit unsigned carry, then control case
    step("u32c", 1'b0, mk_cru(1, 2'b11, 2'b11, 2'b11, 0, 0, 1, 1),
         {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, rnd128());
    check("u32c_const_d0", dst_reg0, 128'd0);
    check("u32c_const_st", st, 128'hF);
    step("u32ok", 1'b0, mk_cru(1, 2'b11, 2'b11, 2'b11, 0, 0, 0, 1),
         {4{32'h1}}, {4{32'h1}}, rnd128());
    check("u32ok_const_d0", dst_reg0, {4{32'h2}});
    check("u32ok_const_st", st, 128'd0);

    // 8/4-bit mode with 0x55 everywhere
    step("u84", 1'b0, mk_cru(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1), P55, P55, P55);
    check("u84_const_d0", dst_reg0, Ones);
    check("u84_const_d1", dst_reg1, Ones);
    check("u84_const_st", st, 128'd0);
    step("s84", 1'b0, mk_cru(1, 2'b00, 2'b00, 2'b00, 1, 1, 1, 1), P55, P55, P55);
    check("s84_const_st", st, {80'd0, 48'hFFFF_FFFF_FFFF});

    // Hold: invalid instruction, then no-op mode, then valid with update_st=0
    step("hold_inv", 1'b0, mk_cru(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 1),
         rnd128(), rnd128(), rnd128());
    check("hold_inv_const_d0", dst_reg0, Ones);
    step("hold_noop", 1'b0, mk_cru(1, 2'b11, 2'b00, 2'b11, 0, 0, 0, 1),
         rnd128(), rnd128(), rnd128());
    step("nost", 1'b0, mk_cru(1, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0),
         {4{32'h1}}, {4{32'h1}}, rnd128());
    check("nost_const_d0", dst_reg0, {4{32'h2}});
    check("nost_const_d1", dst_reg1, 128'd0);
    check("nost_const_st", st, {80'd0, 48'hFFFF_FFFF_FFFF});

    // Reset mid-run, then resume
    step("midrst", 1'b1, mk_cru(1, 2'b00, 2'b00, 2'b00, 1, 1, 1, 1), P55, P55, P55);
    check("midrst_const_d1", dst_reg1, 128'd0);
    step("resume", 1'b0, mk_cru(1, 2'b11, 2'b11, 2'b11, 1, 1, 0, 1),
         {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 128'd0);
    check("resume_const_d0", dst_reg0, {4{32'h8000_0000}});

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin p0 = 2'b11; p1 = 2'b11; p2 = 2'b11; end
        4, 5, 6, 7: begin p0 = 2'b00; p1 = 2'b00; p2 = 2'b00; end
        default: begin
          p0 = 2'($urandom());
          p1 = 2'($urandom());
          p2 = 2'($urandom());
        end
      endcase
      c = mk_cru($urandom_range(0, 9) < 8, p0, p1, p2, 1'($urandom()), 1'($urandom()),
                 1'($urandom()), $urandom_range(0, 9) < 7);
      step("rnd", $urandom_range(0, 99) < 3, c, rnd_src(), rnd_src(), rnd_src());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
